// File: rtl/x68_line_writer.sv
// x68_line_writer: fills one bank of the ping-pong line RAM per line start, from the compositor or with zeros
module x68_line_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              gclk,
    input  logic              rstn,
    input  logic              hcomp,
    input  logic              lramsel,
    input  logic              line_active,
    input  logic [9:0]        next_line,
    input  logic [ADDR_W-1:0] hdisp_words,
    output logic              line_req,
    output logic [9:0]        req_line,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr
);

    typedef enum logic [1:0] {IDLE, REQ, FILL, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              bank;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] cnt;
    logic [9:0]        line;
    logic              hs;
    logic              at_last;

    assign hs      = src_valid && state == FILL;
    assign at_last = cnt == last;

    // Write port is combinational so an accepted pixel lands in the RAM in its handshake cycle
    always_comb begin
        src_ready = state == FILL;
        wr_en     = hs || state == CLEAR;
        wr_bank   = bank;
        wr_addr   = cnt;
        wr_data   = state == FILL ? src_data : '0;
        line_req  = state == REQ;
        req_line  = line;
        busy      = state != IDLE;
    end

    // Line sequencer: a line start always re-captures and restarts, abandoning any unfinished line
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            bank    <= 1'b0;
            last    <= '0;
            cnt     <= '0;
            line    <= '0;
            overrun <= 1'b0;
        end else begin
            if (ovr_clr)
                overrun <= 1'b0;
            if (hcomp && state != IDLE)
                overrun <= 1'b1;
            if (hcomp) begin
                bank  <= lramsel;
                last  <= hdisp_words - ONE;
                line  <= next_line;
                cnt   <= '0;
                state <= line_active ? REQ : CLEAR;
            end else begin
                case (state)
                    REQ: state <= FILL;
                    FILL: if (hs) begin
                        cnt   <= cnt + ONE;
                        state <= at_last ? IDLE : FILL;
                    end
                    CLEAR: begin
                        cnt   <= cnt + ONE;
                        state <= at_last ? IDLE : CLEAR;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
